// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the 2-read/1-write register file.
//   RF_WIDTH / RF_DEPTH are the default geometry; word_t and addr_t describe
//   that default geometry and are used by anything talking to a default-sized
//   register file.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = $clog2(RF_DEPTH);

    typedef logic [RF_WIDTH-1:0]  word_t;
    typedef logic [RF_ADDR_W-1:0] addr_t;

    localparam addr_t ZERO_ADDR = '0;

endpackage : regfile_pkg

// File: rtl/regfile_word.sv
// -----------------------------------------------------------------------------
// regfile_word
//   One storage word of the register file: a WIDTH-bit register with a
//   synchronous active-high reset and a load enable.
// Ports
//   clk    : clock, state updates on the rising edge
//   reset  : synchronous active-high reset, clears the word
//   load_i : load enable, captures d_i on the next edge
//   d_i    : data to load
//   q_o    : stored word
// -----------------------------------------------------------------------------
module regfile_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

endmodule : regfile_word

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   Register file with one write port and two registered (1-cycle latency)
//   read ports. A read that hits the word being written in the same cycle
//   returns the new write data. With ZERO_REG=1, register 0 is hard-wired to
//   zero: writes are dropped and it never forwards. Addresses >= DEPTH are
//   unmapped: writes are dropped and reads return 0.
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous active-high reset, clears storage and outputs
//   we/waddr/wdata : write port
//   re1/raddr1     : read request port 1, result on rdata1 one edge later
//   re2/raddr2     : read request port 2, result on rdata2 one edge later
//   rdata1/rdata2  : registered read data, held while the read enable is low
// -----------------------------------------------------------------------------
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] load;

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign load[i] = 1'b0;
        end else begin : g_norm
            assign load[i] = we && (waddr == ADDR_W'(i));
        end

        regfile_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .load_i(load[i]),
            .d_i   (wdata),
            .q_o   (mem[i])
        );
    end

    // A write is "effective" only when it actually lands in a word. Using the
    // OR of the loads means forwarding automatically excludes register 0
    // (when hard-wired) and unmapped addresses.
    logic write_hit;
    assign write_hit = |load;

    // ---------------------------------------------------------------------
    // Read path: array mux -> forwarding mux -> output register
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] mux1, mux2;
    logic [WIDTH-1:0] fwd1, fwd2;

    // Compare-based mux so unmapped addresses fall through to 0 without
    // indexing past the end of the array.
    always_comb begin
        mux1 = '0;
        mux2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                mux1 = mem[i];
            end
            if (raddr2 == ADDR_W'(i)) begin
                mux2 = mem[i];
            end
        end
    end

    always_comb begin
        fwd1 = mux1;
        fwd2 = mux2;
        if (write_hit && (raddr1 == waddr)) begin
            fwd1 = wdata;
        end
        if (write_hit && (raddr2 == waddr)) begin
            fwd2 = wdata;
        end
    end

    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic [WIDTH-1:0] rdata2_q, rdata2_d;

    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (re1) begin
            rdata1_d = fwd1;
        end
        if (re2) begin
            rdata2_d = fwd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;

endmodule : regfile_2r1w
